// File: rtl/shift_accum.sv
// shift_accum: handshaked multi-term accumulator with optional shift-by-index
// (shift-and-add multiply) and wrap/saturate overflow handling.
module shift_accum #(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned ACC_W     = 20,
    parameter int unsigned MAX_TERMS = 8,
    parameter int unsigned CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_terms,
    input  logic              shift_mode,
    input  logic              sat_mode,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned SUM_W = ACC_W + IN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] idx;
    logic             shift_q;
    logic             sat_q;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    logic [SUM_W-1:0] addend;
    logic [SUM_W-1:0] sum;
    logic             ovf_event;
    logic             accept;
    logic             last;
    logic [CNT_W-1:0] num_clamped;

    // Datapath: widened addend/sum so any carry past ACC_W is visible.
    always_comb begin
        addend      = shift_q ? (SUM_W'(in_data) << idx) : SUM_W'(in_data);
        sum         = SUM_W'(acc) + addend;
        ovf_event   = |sum[SUM_W-1:ACC_W];
        accept      = (state == ACCUM) && in_valid;
        last        = (idx == count - CNT_W'(1));
        num_clamped = (num_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : num_terms;
    end

    // Control FSM and accumulator; abort overrides every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            idx     <= '0;
            shift_q <= 1'b0;
            sat_q   <= 1'b0;
            acc     <= '0;
            ovf     <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    acc <= '0;
                    idx <= '0;
                    ovf <= 1'b0;
                    if (start) begin
                        count   <= num_clamped;
                        shift_q <= shift_mode;
                        sat_q   <= sat_mode;
                        state   <= (num_clamped == '0) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        idx <= idx + CNT_W'(1);
                        if (ovf_event) begin
                            ovf <= 1'b1;
                            acc <= sat_q ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
                        end else if (sat_q && ovf) begin
                            acc <= {ACC_W{1'b1}};
                        end else begin
                            acc <= sum[ACC_W-1:0];
                        end
                        if (last) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        idx   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake/status outputs decode the state register only.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign acc_out   = acc;
    assign overflow  = ovf;

endmodule

// File: tb/tb_shift_accum.sv
// Self-checking bench for shift_accum: table of runs plus directed
// abort / start-collision / async-reset sequences.
module tb_shift_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  num_terms;
    logic        shift_mode;
    logic        sat_mode;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] acc_out;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shift_accum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_terms  (num_terms),
        .shift_mode (shift_mode),
        .sat_mode   (sat_mode),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc_out    (acc_out),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            sh;
        logic            sa;
        logic [3:0]      num;
        logic [3:0]      nsend;
        logic            bub;
        logic [3:0]      hold;
        logic [7:0][15:0] terms;
        logic [19:0]     exp_acc;
        logic            exp_ovf;
    } vec_t;

    vec_t vecs [10];
    vec_t v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input vec_t r, input string nm);
        int   sent;
        int   cyc;
        logic tog;
        logic rdy;
        num_terms  = r.num;
        shift_mode = r.sh;
        sat_mode   = r.sa;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check({nm, "_busy"}, 32'(busy), 32'd1);
        check({nm, "_ov_early"}, 32'(out_valid), 32'(r.num == 4'd0));
        check({nm, "_rdy_early"}, 32'(in_ready), 32'(r.num != 4'd0));
        sent = 0;
        cyc  = 0;
        tog  = 1'b1;
        while (sent < int'(r.nsend) && cyc < 200) begin
            in_data  = r.terms[sent];
            in_valid = r.bub ? tog : 1'b1;
            tog      = ~tog;
            rdy      = in_ready;
            if (r.bub) check({nm, "_rdy_accum"}, 32'(in_ready), 32'd1);
            tick();
            if (in_valid && rdy) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: sent %0d of %0d terms", nm, sent, r.nsend);
        end
        check({nm, "_ov"}, 32'(out_valid), 32'd1);
        check({nm, "_rdy_hold"}, 32'(in_ready), 32'd0);
        check({nm, "_acc"}, 32'(acc_out), 32'(r.exp_acc));
        check({nm, "_ovf"}, 32'(overflow), 32'(r.exp_ovf));
        for (int h = 0; h < int'(r.hold); h++) begin
            tick();
            check({nm, "_bp_ov"}, 32'(out_valid), 32'd1);
            check({nm, "_bp_acc"}, 32'(acc_out), 32'(r.exp_acc));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, "_post_ov"}, 32'(out_valid), 32'd0);
        check({nm, "_post_busy"}, 32'(busy), 32'd0);
        check({nm, "_post_acc"}, 32'(acc_out), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 4'd0,
                    {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h00AB, 16'h0000, 16'h00AB},
                    20'h00357, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 4'd4, 4'd4, 1'b1, 4'd0,
                    {16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0001, 16'h2000, 16'h1000},
                    20'h13000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 4'd5, 4'd5, 1'b0, 4'd0,
                    {16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hFFFF},
                    20'h0FFEF, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 4'd0,
                    {16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hFFFF},
                    20'hFFFFF, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 4'd2, 4'd2, 1'b0, 4'd5,
                    {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4321, 16'h1234},
                    20'h05555, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd1,
                    {8{16'h0}}, 20'h00000, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 4'd15, 4'd8, 1'b0, 4'd0,
                    {8{16'h0001}}, 20'h000FF, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 4'd8, 4'd8, 1'b0, 4'd0,
                    {8{16'hFFFF}}, 20'hFFFFF, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 4'd8, 4'd8, 1'b0, 4'd0,
                    {8{16'hFFFF}}, 20'hEFF01, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 4'd0,
                    {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000},
                    20'h08000, 1'b0};

        rst_n      = 1'b0;
        start      = 1'b0;
        num_terms  = '0;
        shift_mode = 1'b0;
        sat_mode   = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        #5 rst_n = 1'b1;
        tick();

        // Table-driven runs
        for (int i = 0; i < 10; i++) begin
            do_run(vecs[i], $sformatf("v%0d", i));
        end

        // Abort after 2 of 4 terms; a term offered with abort is dropped
        num_terms = 4'd4; shift_mode = 1'b0; sat_mode = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 16'h0100; tick();
        end
        in_data = 16'h0005; abort = 1'b1; tick();
        abort = 1'b0; in_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdy", 32'(in_ready), 32'd0);
        check("abort_acc", 32'(acc_out), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("abort_ov", 32'(out_valid), 32'd0);
            tick();
        end
        v = '{1'b0, 1'b0, 4'd2, 4'd2, 1'b0, 4'd0,
              {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0001},
              20'h00003, 1'b0};
        do_run(v, "after_abort");

        // start asserted in ACCUM and HOLD is ignored
        num_terms = 4'd2; shift_mode = 1'b0; sat_mode = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 16'h0010; tick();
        in_valid = 1'b0; start = 1'b1; num_terms = 4'd0; tick();
        check("st_accum_busy", 32'(busy), 32'd1);
        check("st_accum_rdy", 32'(in_ready), 32'd1);
        check("st_accum_ov", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 16'h0020; tick();
        in_valid = 1'b0;
        check("st_hold_ov", 32'(out_valid), 32'd1);
        check("st_hold_acc", 32'(acc_out), 32'h30);
        tick();
        check("st_hold_ov2", 32'(out_valid), 32'd1);
        check("st_hold_acc2", 32'(acc_out), 32'h30);
        start = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("st_done_ov", 32'(out_valid), 32'd0);
        check("st_done_busy", 32'(busy), 32'd0);

        // Async reset mid-ACCUM, then a fresh run
        num_terms = 4'd3; shift_mode = 1'b0; sat_mode = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 16'h0100; tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rdy", 32'(in_ready), 32'd0);
        check("arst_ov", 32'(out_valid), 32'd0);
        check("arst_acc", 32'(acc_out), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        v = '{1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 4'd0,
              {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0042},
              20'h00042, 1'b0};
        do_run(v, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
